// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with a direct-mapped branch target buffer.
// Handles boot, halt/resume, trap and execute redirects, and BTB updates.
module fetch_pc_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            RedirectE,
    input  logic [XLEN-1:0] RedirectPCE,
    input  logic            TrapValid,
    input  logic [XLEN-1:0] TrapVec,
    input  logic            HaltReq,
    input  logic            ResumeReq,
    input  logic            UpdE,
    input  logic [XLEN-1:0] UpdPCE,
    input  logic [XLEN-1:0] UpdTargetE,
    input  logic            UpdTakenE,
    output logic [XLEN-1:0] PCF,
    output logic            FetchValidF,
    output logic            PredTakenF
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t state;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];

    logic [IDX-1:0]  rd_idx;
    logic [TAGW-1:0] rd_tag;
    logic [IDX-1:0]  wr_idx;
    logic [TAGW-1:0] wr_tag;
    logic            hit;

    assign rd_idx = PCF[IDX+1:2];
    assign rd_tag = PCF[XLEN-1:IDX+2];
    assign wr_idx = UpdPCE[IDX+1:2];
    assign wr_tag = UpdPCE[XLEN-1:IDX+2];

    // Lookup reads registered contents, so same-cycle writes are not seen.
    assign hit        = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign PredTakenF = FetchValidF & hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            PCF         <= RESET_VEC;
            FetchValidF <= 1'b0;
        end else if (TrapValid) begin
            state       <= RUN;
            PCF         <= TrapVec & ALIGN;
            FetchValidF <= 1'b1;
        end else begin
            unique case (state)
                BOOT: begin
                    state       <= RUN;
                    FetchValidF <= 1'b1;
                end
                RUN: begin
                    if (RedirectE) begin
                        PCF <= RedirectPCE & ALIGN;
                    end else if (HaltReq) begin
                        state       <= HALTED;
                        FetchValidF <= 1'b0;
                    end else if (!StallF) begin
                        if (hit) begin
                            PCF <= btb_target[rd_idx];
                        end else begin
                            PCF <= PCF + XLEN'(4);
                        end
                    end
                end
                HALTED: begin
                    if (ResumeReq) begin
                        state       <= RUN;
                        FetchValidF <= 1'b1;
                    end
                end
                default: begin
                    state       <= BOOT;
                    FetchValidF <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (UpdE) begin
            if (UpdTakenE) begin
                btb_valid[wr_idx] <= 1'b1;
            end else if (btb_tag[wr_idx] == wr_tag) begin
                btb_valid[wr_idx] <= 1'b0;
            end
        end
    end

    // Tags and targets carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst && UpdE && UpdTakenE) begin
            btb_tag[wr_idx]    <= wr_tag;
            btb_target[wr_idx] <= UpdTargetE & ALIGN;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed scenarios plus randomized traffic
// checked against an address-level reference model.
module tb_fetch_pc_unit;

    localparam int          N  = 16;
    localparam logic [31:0] RV = 32'h0;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        RedirectE;
    logic [31:0] RedirectPCE;
    logic        TrapValid;
    logic [31:0] TrapVec;
    logic        HaltReq;
    logic        ResumeReq;
    logic        UpdE;
    logic [31:0] UpdPCE;
    logic [31:0] UpdTargetE;
    logic        UpdTakenE;
    logic [31:0] PCF;
    logic        FetchValidF;
    logic        PredTakenF;

    int checks;
    int passed;

    // Reference model: program counter, mode, and BTB as branch-address map
    logic [31:0] m_pc;
    int          m_mode;
    bit          m_v    [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_tgt  [N];

    fetch_pc_unit #(
        .XLEN(32),
        .RESET_VEC(RV),
        .BTB_ENTRIES(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .StallF(StallF),
        .RedirectE(RedirectE),
        .RedirectPCE(RedirectPCE),
        .TrapValid(TrapValid),
        .TrapVec(TrapVec),
        .HaltReq(HaltReq),
        .ResumeReq(ResumeReq),
        .UpdE(UpdE),
        .UpdPCE(UpdPCE),
        .UpdTargetE(UpdTargetE),
        .UpdTakenE(UpdTakenE),
        .PCF(PCF),
        .FetchValidF(FetchValidF),
        .PredTakenF(PredTakenF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slot(logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic bit m_hit(logic [31:0] a);
        int i;
        i = slot(a);
        return m_v[i] && (m_addr[i][31:2] == a[31:2]);
    endfunction

    task automatic model_step();
        logic [31:0] npc;
        int          nmode;
        int          i;
        npc   = m_pc;
        nmode = m_mode;
        if (rst) begin
            npc   = RV;
            nmode = M_BOOT;
            for (int k = 0; k < N; k++) m_v[k] = 0;
        end else begin
            if (TrapValid) begin
                npc   = TrapVec & ~32'h3;
                nmode = M_RUN;
            end else if (m_mode == M_BOOT) begin
                nmode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (RedirectE) npc = RedirectPCE & ~32'h3;
                else if (HaltReq) nmode = M_HALT;
                else if (StallF) npc = m_pc;
                else if (m_hit(m_pc)) npc = m_tgt[slot(m_pc)];
                else npc = m_pc + 32'd4;
            end else if (ResumeReq) begin
                nmode = M_RUN;
            end
            if (UpdE) begin
                i = slot(UpdPCE);
                if (UpdTakenE) begin
                    m_v[i]    = 1;
                    m_addr[i] = UpdPCE & ~32'h3;
                    m_tgt[i]  = UpdTargetE & ~32'h3;
                end else if (m_addr[i][31:2] == UpdPCE[31:2]) begin
                    m_v[i] = 0;
                end
            end
        end
        m_pc   = npc;
        m_mode = nmode;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst         = 1'b0;
        StallF      = 1'b0;
        RedirectE   = 1'b0;
        RedirectPCE = '0;
        TrapValid   = 1'b0;
        TrapVec     = '0;
        HaltReq     = 1'b0;
        ResumeReq   = 1'b0;
        UpdE        = 1'b0;
        UpdPCE      = '0;
        UpdTargetE  = '0;
        UpdTakenE   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0;
        exp_pc[1] = 32'h4;
        exp_pc[2] = 32'h8;
        idle();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (PCF !== 32'h0 || FetchValidF !== 1'b0 || PredTakenF !== 1'b0)
            $display("FAIL reset_state: pc=%h v=%b p=%b want pc=0 v=0 p=0",
                     PCF, FetchValidF, PredTakenF);
        else passed++;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (PCF !== exp_pc[k] || FetchValidF !== 1'b1)
                $display("FAIL boot_seq%0d: pc=%h v=%b want pc=%h v=1",
                         k, PCF, FetchValidF, exp_pc[k]);
            else passed++;
        end
    endtask

    task automatic test_btb_hit();
        UpdE = 1'b1; UpdTakenE = 1'b1;
        UpdPCE = 32'h10; UpdTargetE = 32'h80;
        tick();
        idle();
        tick();
        checks++;
        if (PCF !== 32'h10 || PredTakenF !== 1'b1)
            $display("FAIL btb_pred: pc=%h p=%b want pc=10 p=1", PCF, PredTakenF);
        else passed++;
        tick();
        checks++;
        if (PCF !== 32'h80)
            $display("FAIL btb_target: pc=%h want 80", PCF);
        else passed++;
        UpdE = 1'b1; UpdTakenE = 1'b0; UpdPCE = 32'h10;
        tick();
        idle();
        RedirectE = 1'b1; RedirectPCE = 32'h10;
        tick();
        idle();
        checks++;
        if (PCF !== 32'h10 || PredTakenF !== 1'b0)
            $display("FAIL btb_clear: pc=%h p=%b want pc=10 p=0", PCF, PredTakenF);
        else passed++;
        tick();
        checks++;
        if (PCF !== 32'h14)
            $display("FAIL btb_fallthru: pc=%h want 14", PCF);
        else passed++;
    endtask

    task automatic test_priority();
        StallF = 1'b1;
        RedirectE = 1'b1; RedirectPCE = 32'h40;
        TrapValid = 1'b1; TrapVec = 32'h100;
        tick();
        idle();
        checks++;
        if (PCF !== 32'h100)
            $display("FAIL trap_over_all: pc=%h want 100", PCF);
        else passed++;
        StallF = 1'b1;
        tick();
        checks++;
        if (PCF !== 32'h100 || FetchValidF !== 1'b1)
            $display("FAIL stall_hold: pc=%h v=%b want pc=100 v=1", PCF, FetchValidF);
        else passed++;
        RedirectE = 1'b1; RedirectPCE = 32'h40;
        tick();
        idle();
        checks++;
        if (PCF !== 32'h40)
            $display("FAIL redirect_over_stall: pc=%h want 40", PCF);
        else passed++;
    endtask

    task automatic test_wrap();
        RedirectE = 1'b1; RedirectPCE = 32'hFFFF_FFFC;
        tick();
        idle();
        checks++;
        if (PCF !== 32'hFFFF_FFFC)
            $display("FAIL redirect_top: pc=%h want fffffffc", PCF);
        else passed++;
        tick();
        checks++;
        if (PCF !== 32'h0)
            $display("FAIL pc_wrap: pc=%h want 0", PCF);
        else passed++;
        RedirectE = 1'b1; RedirectPCE = 32'h43;
        tick();
        idle();
        checks++;
        if (PCF !== 32'h40)
            $display("FAIL redirect_align: pc=%h want 40", PCF);
        else passed++;
    endtask

    task automatic test_halt();
        RedirectE = 1'b1; RedirectPCE = 32'h20;
        tick();
        idle();
        HaltReq = 1'b1;
        tick();
        HaltReq = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (PCF !== 32'h20 || FetchValidF !== 1'b0)
                $display("FAIL halt_hold%0d: pc=%h v=%b want pc=20 v=0",
                         k, PCF, FetchValidF);
            else passed++;
            if (k < 4) tick();
        end
        ResumeReq = 1'b1;
        tick();
        idle();
        checks++;
        if (PCF !== 32'h20 || FetchValidF !== 1'b1)
            $display("FAIL resume: pc=%h v=%b want pc=20 v=1", PCF, FetchValidF);
        else passed++;
        tick();
        checks++;
        if (PCF !== 32'h24)
            $display("FAIL resume_next: pc=%h want 24", PCF);
        else passed++;
    endtask

    task automatic test_trap_halted();
        HaltReq = 1'b1;
        tick();
        TrapValid = 1'b1; TrapVec = 32'h203;
        tick();
        idle();
        checks++;
        if (PCF !== 32'h200 || FetchValidF !== 1'b1)
            $display("FAIL trap_from_halt: pc=%h v=%b want pc=200 v=1",
                     PCF, FetchValidF);
        else passed++;
        tick();
        checks++;
        if (PCF !== 32'h204)
            $display("FAIL trap_next: pc=%h want 204", PCF);
        else passed++;
    endtask

    task automatic test_alias();
        UpdE = 1'b1; UpdTakenE = 1'b1;
        UpdPCE = 32'h10; UpdTargetE = 32'h80;
        tick();
        UpdTakenE = 1'b0;
        UpdPCE = 32'h10 + 32'(4 * N);
        tick();
        idle();
        RedirectE = 1'b1; RedirectPCE = 32'h10;
        tick();
        idle();
        checks++;
        if (PCF !== 32'h10 || PredTakenF !== 1'b1)
            $display("FAIL alias_keep: pc=%h p=%b want pc=10 p=1", PCF, PredTakenF);
        else passed++;
        tick();
        checks++;
        if (PCF !== 32'h80)
            $display("FAIL alias_target: pc=%h want 80", PCF);
        else passed++;
    endtask

    task automatic test_reset_priority();
        rst = 1'b1;
        TrapValid = 1'b1; TrapVec = 32'h300;
        UpdE = 1'b1; UpdTakenE = 1'b1;
        UpdPCE = 32'h30; UpdTargetE = 32'h90;
        tick();
        idle();
        checks++;
        if (PCF !== RV || FetchValidF !== 1'b0 || PredTakenF !== 1'b0)
            $display("FAIL reset_prio: pc=%h v=%b p=%b want pc=0 v=0 p=0",
                     PCF, FetchValidF, PredTakenF);
        else passed++;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (PCF !== 32'h10 || PredTakenF !== 1'b0)
            $display("FAIL reset_btb_clear: pc=%h p=%b want pc=10 p=0",
                     PCF, PredTakenF);
        else passed++;
        tick();
        checks++;
        if (PCF !== 32'h14)
            $display("FAIL reset_btb_next: pc=%h want 14", PCF);
        else passed++;
    endtask

    task automatic test_random();
        logic exp_v;
        logic exp_p;
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            TrapValid   = ($urandom_range(0, 99) < 5);
            TrapVec     = $urandom_range(0, 511);
            RedirectE   = ($urandom_range(0, 99) < 10);
            RedirectPCE = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255))
                                                      : $urandom_range(0, 511);
            StallF      = ($urandom_range(0, 99) < 20);
            HaltReq     = ($urandom_range(0, 99) < 8);
            ResumeReq   = ($urandom_range(0, 99) < 30);
            UpdE        = ($urandom_range(0, 99) < 35);
            UpdTakenE   = ($urandom_range(0, 99) < 60);
            UpdPCE      = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
            UpdTargetE  = $urandom_range(0, 511);
            tick();
            exp_v = (m_mode == M_RUN);
            exp_p = exp_v && m_hit(m_pc);
            checks++;
            if (PCF !== m_pc)
                $display("FAIL rand_pc[%0d]: pc=%h want %h", n, PCF, m_pc);
            else passed++;
            checks++;
            if (FetchValidF !== exp_v)
                $display("FAIL rand_valid[%0d]: v=%b want %b", n, FetchValidF, exp_v);
            else passed++;
            checks++;
            if (PredTakenF !== exp_p)
                $display("FAIL rand_pred[%0d]: p=%b want %b", n, PredTakenF, exp_p);
            else passed++;
        end
        idle();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        m_pc   = '0;
        m_mode = M_BOOT;
        for (int k = 0; k < N; k++) begin
            m_v[k]    = 0;
            m_addr[k] = '0;
            m_tgt[k]  = '0;
        end
        idle();
        test_reset();
        test_btb_hit();
        test_priority();
        test_wrap();
        test_halt();
        test_trap_halted();
        test_alias();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
